xrv_dmem: RTL



---
 rtl/xrv_dmem.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/xrv_dmem.sv
// Data-side load/store responder: byte-enabled RAM, console FIFO + cycle counter MMIO, unmapped error flag.
// Latency: ready in cycle T+1+RD_WAIT/WR_WAIT after the request is first sampled in T; console-full stalls add cycles.
// Backpressure: requests are held by the core until ready; console writes stall while the FIFO is full, drain via con_valid/con_ready.

// Generic synchronous FIFO with occupancy count; push while full and pop while empty are ignored.
module xrv_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // pointers and occupancy; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module xrv_dmem #(
  parameter int          ADDR_W     = 12,
  parameter int          RD_WAIT    = 0,
  parameter int          WR_WAIT    = 0,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_wr_req,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic        d_wr_ready,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        err
);
  localparam int         CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] RD_W  = 4'(RD_WAIT);
  localparam logic [3:0] WR_W  = 4'(WR_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, STALL, RESP} state_t;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         wcnt;
  logic               lat_rd;
  logic [31:2]        lat_addr;
  logic [3:0]         lat_be;
  logic [31:0]        lat_dat;
  logic [31:0]        ram [2**ADDR_W];
  logic [31:0]        ram_q;
  logic [31:0]        cyc_q;
  logic [31:0]        cyc_merged;
  logic               err_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [7:0]         fifo_head;
  logic               latch;
  logic               hit_ram;
  logic               hit_mmio;
  logic [1:0]         reg_sel;
  logic               con_wr;
  logic               stall_cond;
  logic               resp_fire;
  logic [31:0]        rdata;
  logic               unused_addr_lsbs;

  // byte offset within a word plays no part in decode
  assign unused_addr_lsbs = ^d_addr[1:0];

  assign latch      = (state == IDLE) && (d_rd_req || d_wr_req);
  assign hit_ram    = (lat_addr[31:ADDR_W+2] == '0);
  assign hit_mmio   = (lat_addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel    = lat_addr[3:2];
  assign con_wr     = !lat_rd && hit_mmio && (reg_sel == 2'd0);
  assign stall_cond = con_wr && fifo_full;
  // the single cycle in which a transaction completes; reset in that cycle aborts it
  assign resp_fire  = (state == RESP) && !stall_cond && !rst;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nx   = state;
    d_rd_ready = 1'b0;
    d_wr_ready = 1'b0;
    case (state)
      IDLE:  if (latch) state_nx = (((d_rd_req ? RD_W : WR_W)) == 4'd0) ? RESP : WAIT;
      WAIT:  if (wcnt == 4'd1) state_nx = stall_cond ? STALL : RESP;
      STALL: if (!fifo_full) state_nx = RESP;
      RESP:  state_nx = stall_cond ? STALL : IDLE;
      default: state_nx = IDLE;
    endcase
    if (resp_fire) begin
      d_rd_ready = lat_rd && d_rd_req;
      d_wr_ready = !lat_rd && d_wr_req;
    end
  end

  // capture the request and run the wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_rd   <= 1'b0;
      lat_addr <= '0;
      lat_be   <= '0;
      lat_dat  <= '0;
      wcnt     <= '0;
    end else if (latch) begin
      lat_rd   <= d_rd_req;
      lat_addr <= d_addr[31:2];
      lat_be   <= d_be;
      lat_dat  <= d_wr_data;
      wcnt     <= d_rd_req ? RD_W : WR_W;
    end else if (state == WAIT) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // RAM: read launched at capture, byte-lane write committed in the completing cycle
  always_ff @(posedge clk) begin
    if (latch) ram_q <= ram[d_addr[ADDR_W+1:2]];
    if (resp_fire && !lat_rd && hit_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) ram[lat_addr[ADDR_W+1:2]][8*i +: 8] <= lat_dat[8*i +: 8];
      end
    end
  end

  // cycle counter value with the written lanes substituted
  always_comb begin
    cyc_merged = cyc_q;
    for (int i = 0; i < 4; i++) begin
      if (lat_be[i]) cyc_merged[8*i +: 8] = lat_dat[8*i +: 8];
    end
  end

  // free-running cycle counter, loadable from the CYCLE register
  always_ff @(posedge clk) begin
    if (rst)
      cyc_q <= '0;
    else if (resp_fire && !lat_rd && hit_mmio && (reg_sel == 2'd2))
      cyc_q <= cyc_merged;
    else
      cyc_q <= cyc_q + 32'd1;
  end

  // sticky flag for any access outside RAM and MMIO
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (resp_fire && !hit_ram && !hit_mmio)
      err_q <= 1'b1;
  end

  // read data selection by target
  always_comb begin
    rdata = 32'hDEAD_BEEF;
    if (hit_ram) begin
      rdata = ram_q;
    end else if (hit_mmio) begin
      case (reg_sel)
        2'd1:    rdata = {8'(fifo_count), 22'd0, fifo_empty, fifo_full};
        2'd2:    rdata = cyc_q;
        default: rdata = '0;
      endcase
    end
  end

  assign d_rd_data = d_rd_ready ? rdata : '0;
  assign err       = err_q;
  assign con_valid = !fifo_empty;
  assign con_data  = fifo_head;

  xrv_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (resp_fire && con_wr),
    .push_dat (lat_dat[7:0]),
    .pop      (con_valid && con_ready),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
endmodule
